// File: rtl/quad_pkg.sv
// Shared step encoding and quadrature decode for the encoder bank.
// Used by quad_channel and quad_decoder_bank.
package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN,
        STEP_ERR
    } quad_step_e;

    // Gray position of {A,B}: 00=0, 01=1, 11=2, 10=3
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] pos;
        unique case (ab)
            2'b00:   pos = 2'd0;
            2'b01:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    function automatic quad_step_e quad_decode(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        logic [1:0] diff;
        quad_step_e step;
        diff = gray_pos(cur) - gray_pos(prev);
        unique case (diff)
            2'd0:    step = STEP_NONE;
            2'd1:    step = STEP_UP;
            2'd3:    step = STEP_DN;
            default: step = STEP_ERR;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: synchroniser, glitch filter, decoder, counter, error bit.
// Velocity accumulator present only when QUAD_VELOCITY_EN is defined.
module quad_channel
    import quad_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             quad_a_i,
    input  logic             quad_b_i,
    input  logic             cnt_clr_i,
    input  logic             err_clr_i,
`ifdef QUAD_VELOCITY_EN
    input  logic             win_end_i,
    output logic [CNT_W-1:0] vel_o,
`endif
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic             err_o
);

    localparam int RUN_W = $clog2(FILT_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);

    logic [1:0]            sync1_q;
    logic [1:0]            sync2_q;
    logic [1:0]            warm_q;
    logic                  filt_en;
    logic [1:0][RUN_W-1:0] run_q;
    logic [1:0][RUN_W-1:0] run_d;
    logic [1:0]            cand_q;
    logic [1:0]            filt_q;
    logic [1:0]            filt_d;
    logic [1:0]            fvld_q;
    logic [1:0]            fvld_d;
    logic [1:0]            prev_q;
    logic                  primed_q;
    quad_step_e            step;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  err_q;
    logic                  err_d;

    // Filter waits until the synchroniser holds real pin samples
    assign filt_en = (warm_q == 2'd2);

    always_comb begin
        run_d  = run_q;
        filt_d = filt_q;
        fvld_d = fvld_q;
        if (filt_en) begin
            for (int p = 0; p < 2; p++) begin
                if (sync2_q[p] != cand_q[p]) begin
                    run_d[p] = RUN_W'(1);
                end else if (run_q[p] != RUN_MAX) begin
                    run_d[p] = run_q[p] + 1'b1;
                end
                if (run_d[p] == RUN_MAX) begin
                    filt_d[p] = sync2_q[p];
                    fvld_d[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        step = STEP_NONE;
        if ((&fvld_q) && primed_q) begin
            step = quad_decode(prev_q, filt_q);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (step == STEP_UP) begin
            cnt_d = cnt_q + 1'b1;
        end else if (step == STEP_DN) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign err_d = (err_q & ~err_clr_i) | (step == STEP_ERR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            warm_q   <= '0;
            run_q    <= '0;
            cand_q   <= '0;
            filt_q   <= '0;
            fvld_q   <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            sync1_q <= {quad_a_i, quad_b_i};
            sync2_q <= sync1_q;
            if (!filt_en) begin
                warm_q <= warm_q + 2'd1;
            end else begin
                cand_q <= sync2_q;
            end
            run_q  <= run_d;
            filt_q <= filt_d;
            fvld_q <= fvld_d;
            if (&fvld_q) begin
                prev_q   <= filt_q;
                primed_q <= 1'b1;
            end
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cnt_nxt_o = cnt_d;
    assign err_o     = err_q;

`ifdef QUAD_VELOCITY_EN
    localparam logic [CNT_W-1:0] SMAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] SMIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    logic [CNT_W-1:0] vel_q;

    // Signed accumulate with saturation; cnt_clr deliberately ignored
    always_comb begin
        acc_d = acc_q;
        case (step)
            STEP_UP: if (acc_q != SMAX) acc_d = acc_q + 1'b1;
            STEP_DN: if (acc_q != SMIN) acc_d = acc_q - 1'b1;
            default: acc_d = acc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            vel_q <= '0;
        end else if (win_end_i) begin
            acc_q <= '0;
            vel_q <= acc_d;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign vel_o = vel_q;
`endif

endmodule

// File: rtl/quad_decoder_bank.sv
// NUM_CH quadrature decoders with coherent snapshot and sticky error bits.
// Define QUAD_VELOCITY_EN to add the windowed velocity outputs (vel_flat).
module quad_decoder_bank
    import quad_pkg::*;
#(
    parameter int NUM_CH   = 12,
    parameter int CNT_W    = 32,
    parameter int FILT_LEN = 4,
    parameter int VEL_WIN  = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       quad_a,
    input  logic [NUM_CH-1:0]       quad_b,
    input  logic [NUM_CH-1:0]       cnt_clr,
    input  logic                    snap_req,
    output logic                    snap_ack,
    output logic [NUM_CH*CNT_W-1:0] count_flat,
    output logic [NUM_CH-1:0]       err_sticky,
`ifdef QUAD_VELOCITY_EN
    output logic [NUM_CH*CNT_W-1:0] vel_flat,
`endif
    input  logic                    err_clr
);

    if (FILT_LEN < 1 || VEL_WIN < 1) begin : g_bad_param
        $error("quad_decoder_bank: FILT_LEN and VEL_WIN must be >= 1");
    end

    logic [NUM_CH*CNT_W-1:0] live_nxt;
    logic [NUM_CH*CNT_W-1:0] snap_q;
    logic                    ack_q;

`ifdef QUAD_VELOCITY_EN
    localparam int WIN_W = (VEL_WIN > 1) ? $clog2(VEL_WIN) : 1;

    logic [WIN_W-1:0] win_q;
    logic             win_end;

    assign win_end = (win_q == WIN_W'(VEL_WIN - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_q <= '0;
        end else if (win_end) begin
            win_q <= '0;
        end else begin
            win_q <= win_q + 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        quad_channel #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .quad_a_i  (quad_a[i]),
            .quad_b_i  (quad_b[i]),
            .cnt_clr_i (cnt_clr[i]),
            .err_clr_i (err_clr),
`ifdef QUAD_VELOCITY_EN
            .win_end_i (win_end),
            .vel_o     (vel_flat[i*CNT_W +: CNT_W]),
`endif
            .cnt_nxt_o (live_nxt[i*CNT_W +: CNT_W]),
            .err_o     (err_sticky[i])
        );
    end

    // Capture next-state counts so the snapshot includes this cycle's steps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_q <= '0;
            ack_q  <= 1'b0;
        end else begin
            ack_q <= snap_req;
            if (snap_req) begin
                snap_q <= live_nxt;
            end
        end
    end

    assign count_flat = snap_q;
    assign snap_ack   = ack_q;

endmodule

// File: tb/tb_quad_decoder_bank.sv
// Directed bench for quad_decoder_bank with immediate-assertion checks.
// Velocity checks are compiled in when QUAD_VELOCITY_EN is defined.
module tb_quad_decoder_bank;

    localparam int NUM_CH   = 12;
    localparam int CNT_W    = 32;
    localparam int FILT_LEN = 4;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NUM_CH-1:0]       quad_a;
    logic [NUM_CH-1:0]       quad_b;
    logic [NUM_CH-1:0]       cnt_clr;
    logic                    snap_req;
    logic                    snap_ack;
    logic [NUM_CH*CNT_W-1:0] count_flat;
    logic [NUM_CH-1:0]       err_sticky;
    logic                    err_clr;
`ifdef QUAD_VELOCITY_EN
    logic [NUM_CH*CNT_W-1:0] vel_flat;
`endif

    logic [0:0] qa_s;
    logic [0:0] qb_s;
    logic [0:0] clr_s;
    logic       snap_s;
    logic       ack_s;
    logic [3:0] cnt_s;
    logic [0:0] err_s;
`ifdef QUAD_VELOCITY_EN
    logic [3:0] vel_s;
`endif

    int checks   = 0;
    int failures = 0;

    logic [1:0] fwd [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    always #5 clk = ~clk;

    quad_decoder_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN)
`ifdef QUAD_VELOCITY_EN
        , .VEL_WIN (100)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .quad_a     (quad_a),
        .quad_b     (quad_b),
        .cnt_clr    (cnt_clr),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .count_flat (count_flat),
        .err_sticky (err_sticky),
`ifdef QUAD_VELOCITY_EN
        .vel_flat   (vel_flat),
`endif
        .err_clr    (err_clr)
    );

    quad_decoder_bank #(
        .NUM_CH   (1),
        .CNT_W    (4),
        .FILT_LEN (FILT_LEN)
`ifdef QUAD_VELOCITY_EN
        , .VEL_WIN (100)
`endif
    ) dut_s (
        .clk        (clk),
        .reset_n    (reset_n),
        .quad_a     (qa_s),
        .quad_b     (qb_s),
        .cnt_clr    (clr_s),
        .snap_req   (snap_s),
        .snap_ack   (ack_s),
        .count_flat (cnt_s),
        .err_sticky (err_s),
`ifdef QUAD_VELOCITY_EN
        .vel_flat   (vel_s),
`endif
        .err_clr    (1'b0)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt(input int ch);
        return count_flat[ch*CNT_W +: CNT_W];
    endfunction

`ifdef QUAD_VELOCITY_EN
    function automatic logic [CNT_W-1:0] vel(input int ch);
        return vel_flat[ch*CNT_W +: CNT_W];
    endfunction
`endif

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input int ch, input logic [1:0] ab);
        quad_a[ch] = ab[1];
        quad_b[ch] = ab[0];
        cyc(8);
    endtask

    task automatic snap();
        snap_req = 1'b1;
        cyc(1);
        snap_req = 1'b0;
        chk("snap_ack", 64'(snap_ack), 64'(1));
    endtask

    task automatic set_ab_s(input logic [1:0] ab);
        qa_s[0] = ab[1];
        qb_s[0] = ab[0];
        cyc(8);
    endtask

    task automatic snap_small();
        snap_s = 1'b1;
        cyc(1);
        snap_s = 1'b0;
        chk("small_ack", 64'(ack_s), 64'(1));
    endtask

    initial begin
        reset_n  = 1'b0;
        quad_a   = '0;
        quad_b   = '0;
        cnt_clr  = '0;
        snap_req = 1'b0;
        err_clr  = 1'b0;
        qa_s     = '0;
        qb_s     = '0;
        clr_s    = '0;
        snap_s   = 1'b0;
        cyc(3);
        chk("rst_count_any", 64'(|count_flat), 64'(0));
        chk("rst_err", 64'(err_sticky), 64'(0));
        chk("rst_ack", 64'(snap_ack), 64'(0));
        reset_n = 1'b1;
        cyc(12);

        // 8 forward steps on ch0
        for (int k = 0; k < 8; k++) set_ab(0, fwd[k%4]);
        snap();
        chk("fwd8_ch0", 64'(cnt(0)), 64'(8));
        chk("fwd8_err", 64'(err_sticky), 64'(0));
        cyc(1);
        chk("ack_idle", 64'(snap_ack), 64'(0));

        // reverse from 0 on ch3 wraps to all ones
        set_ab(3, 2'b10);
        snap();
        chk("rev_ch3", 64'(cnt(3)), 64'(32'hFFFF_FFFF));
        chk("hold_ch0", 64'(cnt(0)), 64'(8));

        // 4-bit instance: max positive +1 wraps to min
        for (int k = 0; k < 7; k++) set_ab_s(fwd[k%4]);
        snap_small();
        chk("small_7", 64'(cnt_s), 64'(7));
        set_ab_s(fwd[3]);
        snap_small();
        chk("small_wrap", 64'(cnt_s), 64'(4'h8));

        // glitch of FILT_LEN-1 cycles on ch1 A is discarded
        quad_a[1] = 1'b1;
        cyc(FILT_LEN - 1);
        quad_a[1] = 1'b0;
        cyc(4);
        snap();
        chk("glitch_short", 64'(cnt(1)), 64'(0));
        cyc(10);
        // pulse of exactly FILT_LEN cycles: 00->10 (-1) then back (+1)
        quad_a[1] = 1'b1;
        cyc(FILT_LEN);
        quad_a[1] = 1'b0;
        cyc(3);
        snap();
        chk("glitch_full_dn", 64'(cnt(1)), 64'(32'hFFFF_FFFF));
        cyc(10);
        snap();
        chk("glitch_full_back", 64'(cnt(1)), 64'(0));
        chk("glitch_err", 64'(err_sticky[1]), 64'(0));

        // illegal 00->11 on ch2
        set_ab(2, 2'b11);
        chk("illegal_err", 64'(err_sticky[2]), 64'(1));
        snap();
        chk("illegal_cnt", 64'(cnt(2)), 64'(0));
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("err_clr", 64'(err_sticky[2]), 64'(0));
        // second illegal 11->00 with err_clr in the same cycle
        quad_a[2] = 1'b0;
        quad_b[2] = 1'b0;
        cyc(FILT_LEN + 2);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("err_clr_race", 64'(err_sticky[2]), 64'(1));
        cyc(4);
        chk("err_hold", 64'(err_sticky[2]), 64'(1));
        chk("err_others", 64'(err_sticky & ~12'h004), 64'(0));
        snap();
        chk("illegal_cnt2", 64'(cnt(2)), 64'(0));

        // cnt_clr + step + snap_req in the same cycle on ch5
        set_ab(5, 2'b01);
        set_ab(5, 2'b11);
        snap();
        chk("ch5_pre", 64'(cnt(5)), 64'(2));
        quad_a[5] = 1'b1;
        quad_b[5] = 1'b0;
        cyc(FILT_LEN + 2);
        cnt_clr[5] = 1'b1;
        snap_req   = 1'b1;
        cyc(1);
        cnt_clr[5] = 1'b0;
        snap_req   = 1'b0;
        chk("clr_ack", 64'(snap_ack), 64'(1));
        chk("clr_ch5", 64'(cnt(5)), 64'(0));
        cyc(8);
        snap();
        chk("clr_ch5_hold", 64'(cnt(5)), 64'(0));
        set_ab(5, 2'b00);
        snap();
        chk("clr_state_kept", 64'(cnt(5)), 64'(1));

        // snap_req held high acks every cycle
        snap_req = 1'b1;
        cyc(1);
        chk("held_ack1", 64'(snap_ack), 64'(1));
        cyc(1);
        chk("held_ack2", 64'(snap_ack), 64'(1));
        snap_req = 1'b0;
        cyc(1);
        chk("held_ack_off", 64'(snap_ack), 64'(0));

        // asynchronous reset mid-operation
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(|count_flat), 64'(0));
        chk("mid_rst_err", 64'(err_sticky), 64'(0));
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        // ch0 re-primes at 00; 10 forward steps 6 cycles apart
        for (int k = 0; k < 10; k++) begin
            quad_a[0] = fwd[k%4][1];
            quad_b[0] = fwd[k%4][0];
            cyc(6);
        end
        // ch3 re-primed at 10; 10->00 is +1
        set_ab(3, 2'b00);
        snap();
        chk("reprime_ch0", 64'(cnt(0)), 64'(10));
        chk("reprime_ch3", 64'(cnt(3)), 64'(1));
        chk("reprime_ch5", 64'(cnt(5)), 64'(0));
`ifdef QUAD_VELOCITY_EN
        cyc(30);
        chk("vel_ch0_win1", 64'(vel(0)), 64'(10));
        chk("vel_ch3_win1", 64'(vel(3)), 64'(1));
        cyc(100);
        chk("vel_ch0_win2", 64'(vel(0)), 64'(0));
        chk("vel_ch3_win2", 64'(vel(3)), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
